// File: rtl/bp_update_queue.sv
// rtl/bp_update_queue.sv - commit-side branch predictor update FIFO with mispredict redirect
//
// Purpose: buffers up to two retired branches per cycle in an in-order FIFO, drains one
// entry per cycle to the predictor update port, raises a registered redirect on the first
// accepted mispredicting lane and keeps a saturating mispredict counter.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   commit_*_i                 two commit lanes (lane 0 older): valid, pc, taken, target,
//                              indirect, predicted direction, predicted target
//   enq_ready_o                FIFO has room for two entries (registered occupancy only)
//   update_*_o                 predictor update strobe and payload
//   mispredict_o               one-cycle redirect pulse, redirect_pc_o is the correct next PC
//   mispredict_count_o         saturating count of redirect pulses
//   overflow_err_o             sticky: a lane was offered while not ready
//   count_o                    FIFO occupancy
module bp_update_queue #(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              commit_valid_i,
   input  logic [1:0][63:0]        commit_pc_i,
   input  logic [1:0]              commit_taken_i,
   input  logic [1:0][63:0]        commit_target_i,
   input  logic [1:0]              commit_indirect_i,
   input  logic [1:0]              commit_pred_taken_i,
   input  logic [1:0][63:0]        commit_pred_target_i,
   output logic                    enq_ready_o,
   output logic                    update_valid_o,
   output logic [63:0]             update_pc_o,
   output logic                    update_taken_o,
   output logic [63:0]             update_target_o,
   output logic                    update_is_branch_o,
   output logic                    update_is_indirect_o,
   output logic                    mispredict_o,
   output logic [63:0]             redirect_pc_o,
   output logic [31:0]             mispredict_count_o,
   output logic                    overflow_err_o,
   output logic [$clog2(DEPTH):0]  count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // FIFO storage; contents need no reset because occupancy gates every read.
   logic [63:0]      pc_mem  [DEPTH];
   logic [63:0]      tgt_mem [DEPTH];
   logic [DEPTH-1:0] taken_mem;
   logic [DEPTH-1:0] ind_mem;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, lane1_ptr;
   logic [CW-1:0] count_q, count_d;
   logic          update_valid_q, update_taken_q, update_ind_q;
   logic [63:0]   update_pc_q, update_target_q;
   logic          mispredict_q, overflow_q;
   logic [63:0]   redirect_pc_q, redirect_pc_d;
   logic [31:0]   mis_count_q;

   logic          enq_ready, deq, mis_any;
   logic [1:0]    mis, acc, n_enq;
   logic          redir_lane;

   assign enq_ready = (count_q <= CW'(DEPTH - 2));
   assign deq       = (count_q != '0);

   always_comb begin
      mis = '0;
      for (int i = 0; i < 2; i++) begin
         mis[i] = (commit_pred_taken_i[i] != commit_taken_i[i]) |
                  (commit_taken_i[i] & (commit_pred_target_i[i] != commit_target_i[i]));
      end
      acc[0] = enq_ready & commit_valid_i[0];
      // A mispredicting valid lane 0 makes lane 1 wrong-path: drop it silently.
      acc[1] = enq_ready & commit_valid_i[1] & ~(commit_valid_i[0] & mis[0]);
      n_enq  = {1'b0, acc[0]} + {1'b0, acc[1]};

      // Compaction: lane 1 lands at wr_ptr when lane 0 is not enqueued.
      lane1_ptr = acc[0] ? wr_ptr_q + PW'(1) : wr_ptr_q;
      wr_ptr_d  = wr_ptr_q + PW'(n_enq);
      rd_ptr_d  = rd_ptr_q + PW'(deq);
      count_d   = count_q + CW'(n_enq) - CW'(deq);

      mis_any    = (acc[0] & mis[0]) | (acc[1] & mis[1]);
      redir_lane = ~(acc[0] & mis[0]);
      redirect_pc_d = commit_taken_i[redir_lane] ? commit_target_i[redir_lane]
                                                 : commit_pc_i[redir_lane] + 64'd4;
   end

   always_ff @(posedge clk) begin
      if (acc[0]) begin
         pc_mem[wr_ptr_q]    <= commit_pc_i[0];
         tgt_mem[wr_ptr_q]   <= commit_target_i[0];
         taken_mem[wr_ptr_q] <= commit_taken_i[0];
         ind_mem[wr_ptr_q]   <= commit_indirect_i[0];
      end
      if (acc[1]) begin
         pc_mem[lane1_ptr]    <= commit_pc_i[1];
         tgt_mem[lane1_ptr]   <= commit_target_i[1];
         taken_mem[lane1_ptr] <= commit_taken_i[1];
         ind_mem[lane1_ptr]   <= commit_indirect_i[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         update_valid_q  <= 1'b0;
         update_pc_q     <= '0;
         update_taken_q  <= 1'b0;
         update_target_q <= '0;
         update_ind_q    <= 1'b0;
         mispredict_q    <= 1'b0;
         redirect_pc_q   <= '0;
         mis_count_q     <= '0;
         overflow_q      <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         update_valid_q <= deq;
         if (deq) begin
            update_pc_q     <= pc_mem[rd_ptr_q];
            update_target_q <= tgt_mem[rd_ptr_q];
            update_taken_q  <= taken_mem[rd_ptr_q];
            update_ind_q    <= ind_mem[rd_ptr_q];
         end
         mispredict_q <= mis_any;
         if (mis_any) begin
            redirect_pc_q <= redirect_pc_d;
            if (mis_count_q != 32'hFFFF_FFFF) begin
               mis_count_q <= mis_count_q + 32'd1;
            end
         end
         if (!enq_ready && (|commit_valid_i)) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign enq_ready_o          = enq_ready;
   assign update_valid_o       = update_valid_q;
   assign update_pc_o          = update_pc_q;
   assign update_taken_o       = update_taken_q;
   assign update_target_o      = update_target_q;
   assign update_is_branch_o   = update_valid_q & ~update_ind_q;
   assign update_is_indirect_o = update_valid_q & update_ind_q;
   assign mispredict_o         = mispredict_q;
   assign redirect_pc_o        = redirect_pc_q;
   assign mispredict_count_o   = mis_count_q;
   assign overflow_err_o       = overflow_q;
   assign count_o              = count_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// tb/tb_bp_update_queue.sv - directed self-checking bench for bp_update_queue
module tb_bp_update_queue;
   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       commit_valid_i;
   logic [1:0][63:0] commit_pc_i;
   logic [1:0]       commit_taken_i;
   logic [1:0][63:0] commit_target_i;
   logic [1:0]       commit_indirect_i;
   logic [1:0]       commit_pred_taken_i;
   logic [1:0][63:0] commit_pred_target_i;
   logic             enq_ready_o;
   logic             update_valid_o;
   logic [63:0]      update_pc_o;
   logic             update_taken_o;
   logic [63:0]      update_target_o;
   logic             update_is_branch_o;
   logic             update_is_indirect_o;
   logic             mispredict_o;
   logic [63:0]      redirect_pc_o;
   logic [31:0]      mispredict_count_o;
   logic             overflow_err_o;
   logic [3:0]       count_o;

   bp_update_queue #(.DEPTH(8)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .commit_valid_i       (commit_valid_i),
      .commit_pc_i          (commit_pc_i),
      .commit_taken_i       (commit_taken_i),
      .commit_target_i      (commit_target_i),
      .commit_indirect_i    (commit_indirect_i),
      .commit_pred_taken_i  (commit_pred_taken_i),
      .commit_pred_target_i (commit_pred_target_i),
      .enq_ready_o          (enq_ready_o),
      .update_valid_o       (update_valid_o),
      .update_pc_o          (update_pc_o),
      .update_taken_o       (update_taken_o),
      .update_target_o      (update_target_o),
      .update_is_branch_o   (update_is_branch_o),
      .update_is_indirect_o (update_is_indirect_o),
      .mispredict_o         (mispredict_o),
      .redirect_pc_o        (redirect_pc_o),
      .mispredict_count_o   (mispredict_count_o),
      .overflow_err_o       (overflow_err_o),
      .count_o              (count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic        taken;
      logic [63:0] tgt;
      logic        ind;
   } ent_t;

   ent_t sb[$];
   int   checks = 0;
   int   failures = 0;
   logic exp_ovf = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_lane(input int l, input logic [63:0] pc, input logic tk,
                           input logic [63:0] tg, input logic ind, input logic ptk,
                           input logic [63:0] ptg);
      commit_valid_i[l]       = 1'b1;
      commit_pc_i[l]          = pc;
      commit_taken_i[l]       = tk;
      commit_target_i[l]      = tg;
      commit_indirect_i[l]    = ind;
      commit_pred_taken_i[l]  = ptk;
      commit_pred_target_i[l] = ptg;
   endtask

   // acc: lanes expected to be enqueued (hand-determined); exp_mis: expected redirect pulse.
   task automatic step(input logic [1:0] acc, input logic exp_mis, input string tag);
      ent_t e;
      logic got_pop;
      got_pop = (sb.size() > 0);
      if (got_pop) e = sb.pop_front();
      for (int i = 0; i < 2; i++) begin
         if (acc[i]) sb.push_back('{commit_pc_i[i], commit_taken_i[i],
                                    commit_target_i[i], commit_indirect_i[i]});
      end
      @(posedge clk);
      #1;
      commit_valid_i = 2'b00;
      chk({tag, "_uv"}, 64'(update_valid_o), 64'(got_pop));
      if (got_pop) begin
         chk({tag, "_pc"},  update_pc_o, e.pc);
         chk({tag, "_tk"},  64'(update_taken_o), 64'(e.taken));
         chk({tag, "_tgt"}, update_target_o, e.tgt);
         chk({tag, "_br"},  64'(update_is_branch_o), 64'(!e.ind));
         chk({tag, "_ind"}, 64'(update_is_indirect_o), 64'(e.ind));
      end
      chk({tag, "_cnt"}, 64'(count_o), 64'(sb.size()));
      chk({tag, "_rdy"}, 64'(enq_ready_o), 64'(sb.size() <= 6));
      chk({tag, "_mis"}, 64'(mispredict_o), 64'(exp_mis));
   endtask

   initial begin
      rst_n = 1'b0;
      commit_valid_i = '0; commit_pc_i = '0; commit_taken_i = '0; commit_target_i = '0;
      commit_indirect_i = '0; commit_pred_taken_i = '0; commit_pred_target_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_uv", 64'(update_valid_o), 0);
      chk("rst_cnt", 64'(count_o), 0);
      chk("rst_mis", 64'(mispredict_o), 0);
      chk("rst_redir", redirect_pc_o, 0);
      chk("rst_mcnt", 64'(mispredict_count_o), 0);
      chk("rst_ovf", 64'(overflow_err_o), 0);
      chk("rst_upc", update_pc_o, 0);
      chk("rst_rdy", 64'(enq_ready_o), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Correctly predicted taken direct branch, two-edge latency.
      set_lane(0, 64'h1000, 1'b1, 64'h2000, 1'b0, 1'b1, 64'h2000);
      step(2'b01, 1'b0, "t1_enq");
      step(2'b00, 1'b0, "t1_drain");
      chk("t1_uv_after", 64'(update_valid_o), 1);

      // Lane 0 direction mispredict; lane 1 is wrong-path.
      set_lane(0, 64'h1100, 1'b1, 64'h3000, 1'b0, 1'b0, 64'h0);
      set_lane(1, 64'h1200, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      step(2'b01, 1'b1, "t2_enq");
      chk("t2_redir", redirect_pc_o, 64'h3000);
      chk("t2_mcnt", 64'(mispredict_count_o), 1);
      step(2'b00, 1'b0, "t2_drain");
      chk("t2_redir_hold", redirect_pc_o, 64'h3000);

      // Not-taken mispredict redirects to fall-through.
      set_lane(0, 64'h4000, 1'b0, 64'h0, 1'b0, 1'b1, 64'h4800);
      step(2'b01, 1'b1, "t3_enq");
      chk("t3_redir", redirect_pc_o, 64'h4004);
      chk("t3_mcnt", 64'(mispredict_count_o), 2);
      step(2'b00, 1'b0, "t3_drain");

      // Indirect target mispredict.
      set_lane(0, 64'h4100, 1'b1, 64'h6000, 1'b1, 1'b1, 64'h5000);
      step(2'b01, 1'b1, "t4_enq");
      chk("t4_redir", redirect_pc_o, 64'h6000);
      chk("t4_mcnt", 64'(mispredict_count_o), 3);
      step(2'b00, 1'b0, "t4_drain");
      chk("t4_ind", 64'(update_is_indirect_o), 1);

      // Lane 0 correct, lane 1 mispredicts: both enqueued, redirect from lane 1.
      set_lane(0, 64'h4200, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      set_lane(1, 64'h4300, 1'b1, 64'h7000, 1'b0, 1'b0, 64'h0);
      step(2'b11, 1'b1, "t5_enq");
      chk("t5_redir", redirect_pc_o, 64'h7000);
      chk("t5_mcnt", 64'(mispredict_count_o), 4);
      step(2'b00, 1'b0, "t5_d0");
      step(2'b00, 1'b0, "t5_d1");

      // Lone lane 1 is compacted to wr_ptr.
      set_lane(1, 64'h4400, 1'b1, 64'h4480, 1'b0, 1'b1, 64'h4480);
      step(2'b10, 1'b0, "t6_enq");
      step(2'b00, 1'b0, "t6_drain");

      // Two correct branches per cycle for 8 cycles; overflow and pointer wrap.
      for (int k = 0; k < 8; k++) begin
         logic rdy;
         rdy = (sb.size() <= 6);
         set_lane(0, 64'h8000 + 64'(k * 16), 1'b1, 64'hA000 + 64'(k * 16), 1'b0, 1'b1,
                  64'hA000 + 64'(k * 16));
         set_lane(1, 64'h8008 + 64'(k * 16), 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
         if (!rdy) exp_ovf = 1'b1;
         step(rdy ? 2'b11 : 2'b00, 1'b0, "fill");
         chk("fill_ovf", 64'(overflow_err_o), 64'(exp_ovf));
      end
      chk("fill_ovf_seen", 64'(overflow_err_o), 1);
      for (int k = 0; k < 12; k++) begin
         if (sb.size() > 0) step(2'b00, 1'b0, "drain");
      end
      chk("drain_sb_empty", 64'(sb.size()), 0);
      step(2'b00, 1'b0, "drain_idle");

      // Fill to 4 with a pending redirect, then reset asynchronously mid-drain.
      set_lane(0, 64'h9000, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      set_lane(1, 64'h9008, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      step(2'b11, 1'b0, "r_f0");
      set_lane(0, 64'h9010, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      set_lane(1, 64'h9018, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      step(2'b11, 1'b0, "r_f1");
      set_lane(0, 64'h9020, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      set_lane(1, 64'h9028, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      step(2'b11, 1'b0, "r_f2");
      set_lane(0, 64'h9030, 1'b1, 64'h9100, 1'b0, 1'b0, 64'h0);
      set_lane(1, 64'h9038, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      step(2'b01, 1'b1, "r_f3");
      chk("r_mcnt", 64'(mispredict_count_o), 5);
      rst_n = 1'b0;
      #1;
      chk("r_uv", 64'(update_valid_o), 0);
      chk("r_cnt", 64'(count_o), 0);
      chk("r_mis", 64'(mispredict_o), 0);
      chk("r_mcnt0", 64'(mispredict_count_o), 0);
      chk("r_ovf", 64'(overflow_err_o), 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(2'b00, 1'b0, "r_idle");
      set_lane(0, 64'hB000, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      step(2'b01, 1'b0, "r_enq");
      step(2'b00, 1'b0, "r_drain");
      step(2'b00, 1'b0, "r_empty");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
